// File: rtl/jt7759_rom_arb.sv
// jt7759_rom_arb: shares one ROM/SDRAM read port between two ADPCM sample
// controllers. Reads are serialised with round-robin priority and each
// requester keeps a one-byte tagged buffer.
//
// Build option: JT7759_ARB_CACHE_EN keeps a requester's buffered byte valid
// while its cs is low, so re-reads of the last address hit with no latency.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   cs0/1, addr0/1     requester read strobe and byte address
//   data0/1            requester buffered byte (registered)
//   ok0/1              requester data valid for current address (combinational)
//   mem_cs, mem_addr   memory read request and address (registered)
//   mem_data, mem_ok   memory read data and data-valid strobe
module jt7759_rom_arb #(
    parameter int unsigned AW = 17
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cs0,
    input  logic [AW-1:0] addr0,
    output logic [7:0]    data0,
    output logic          ok0,
    input  logic          cs1,
    input  logic [AW-1:0] addr1,
    output logic [7:0]    data1,
    output logic          ok1,
    output logic          mem_cs,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    input  logic          mem_ok
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} st_t;

    st_t           st, st_nx;
    logic          gnt, gnt_nx;
    logic          last;
    logic          start, done;
    logic          pend0, pend1;
    logic [AW-1:0] tag0, tag1;
    logic          valid0, valid1;

    // Hit detection against each requester's buffered tag
    assign ok0   = cs0 && valid0 && (addr0 == tag0);
    assign ok1   = cs1 && valid1 && (addr1 == tag1);
    assign pend0 = cs0 && !ok0;
    assign pend1 = cs1 && !ok1;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st  <= IDLE;
            gnt <= 1'b0;
        end else begin
            st  <= st_nx;
            gnt <= gnt_nx;
        end
    end

    // Next state and grant selection; a tie goes to the requester not served last
    always_comb begin
        st_nx  = st;
        gnt_nx = gnt;
        start  = 1'b0;
        done   = 1'b0;
        case (st)
            IDLE: begin
                if (pend0 || pend1) begin
                    start  = 1'b1;
                    st_nx  = ISSUE;
                    gnt_nx = (pend0 && pend1) ? !last : pend1;
                end
            end
            ISSUE: st_nx = WAIT;
            WAIT: begin
                if (mem_ok) begin
                    done  = 1'b1;
                    st_nx = IDLE;
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    // Memory port and round-robin history
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_cs   <= 1'b0;
            mem_addr <= '0;
            last     <= 1'b1;
        end else if (start) begin
            mem_cs   <= 1'b1;
            mem_addr <= gnt_nx ? addr1 : addr0;
        end else if (done) begin
            mem_cs   <= 1'b0;
            last     <= gnt;
        end
    end

    // Requester 0 buffer; the fetched byte is stored under the issued address
    // even if the requester moved on meanwhile
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag0   <= '0;
            data0  <= 8'h00;
            valid0 <= 1'b0;
        end else begin
            if (done && !gnt) begin
                tag0  <= mem_addr;
                data0 <= mem_data;
            end
`ifdef JT7759_ARB_CACHE_EN
            if (done && !gnt) valid0 <= 1'b1;
`else
            if (done && !gnt && cs0) valid0 <= 1'b1;
            else if (!cs0)           valid0 <= 1'b0;
`endif
        end
    end

    // Requester 1 buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag1   <= '0;
            data1  <= 8'h00;
            valid1 <= 1'b0;
        end else begin
            if (done && gnt) begin
                tag1  <= mem_addr;
                data1 <= mem_data;
            end
`ifdef JT7759_ARB_CACHE_EN
            if (done && gnt) valid1 <= 1'b1;
`else
            if (done && gnt && cs1) valid1 <= 1'b1;
            else if (!cs1)          valid1 <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_jt7759_rom_arb.sv
// Testbench for jt7759_rom_arb: directed stimulus with a scoreboard. Expected
// memory addresses and requester data bytes are queued by the stimulus and
// popped by a monitor on each rising mem_cs / ok0 / ok1.
module tb_jt7759_rom_arb;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cs0 = 1'b0, cs1 = 1'b0;
    logic [16:0] addr0 = '0, addr1 = '0;
    logic [7:0]  data0, data1;
    logic        ok0, ok1;
    logic        mem_cs;
    logic [16:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic        mem_ok = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] q_mem[$];
    logic [31:0] q_ok0[$];
    logic [31:0] q_ok1[$];

    // memory responder controls
    bit auto_mem = 1'b1;
    int lat = 0;
    int cnt = 0;
    int stray_cnt = 0;

    jt7759_rom_arb #(.AW(17)) dut (
        .clk(clk), .rstn(rstn),
        .cs0(cs0), .addr0(addr0), .data0(data0), .ok0(ok0),
        .cs1(cs1), .addr1(addr1), .data1(data1), .ok1(ok1),
        .mem_cs(mem_cs), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ok(mem_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom(input logic [16:0] a);
        case (a)
            17'h00123: rom = 8'hA5;
            17'h00055: rom = 8'h3C;
            default:   rom = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_pop(input string name, input logic [31:0] act, inout logic [31:0] q[$]);
        if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected event actual=%h expected=none t=%0t", name, act, $time);
        end else begin
            chk(name, act, q.pop_front());
        end
    endtask

    // Memory model: mem_ok in the (lat+1)-th WAIT cycle, one-cycle pulse
    always @(negedge clk) begin
        if (!auto_mem) begin
            cnt = 0;
            mem_ok = (stray_cnt > 0);
            mem_data = 8'hEE;
            if (stray_cnt > 0) stray_cnt--;
        end else if (mem_ok) begin
            mem_ok = 1'b0;
            cnt = 0;
        end else if (mem_cs) begin
            cnt++;
            if (cnt >= 2 + lat) begin
                mem_ok = 1'b1;
                mem_data = rom(mem_addr);
            end
        end else begin
            cnt = 0;
        end
    end

    // Scoreboard monitor
    logic mcs_q = 1'b0, ok0_q = 1'b0, ok1_q = 1'b0;
    always @(negedge clk) begin
        if (mem_cs && !mcs_q) chk_pop("mem_addr", 32'(mem_addr), q_mem);
        if (ok0 && !ok0_q)    chk_pop("data0", 32'(data0), q_ok0);
        if (ok1 && !ok1_q)    chk_pop("data1", 32'(data1), q_ok1);
        mcs_q = mem_cs;
        ok0_q = ok0;
        ok1_q = ok1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ok(input int ch, input int max);
        int n = 0;
        @(negedge clk);
        while (!(ch == 1 ? ok1 : ok0) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("wait_ok%0d", ch), 32'(ch == 1 ? ok1 : ok0), 32'd1);
    endtask

    task automatic wait_mem_cs(input int max);
        int n = 0;
        @(negedge clk);
        while (!mem_cs && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_mem_cs", 32'(mem_cs), 32'd1);
    endtask

    task automatic drop_all();
        cyc();
        cs0 = 1'b0;
        cs1 = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state; cs0 with addr 0 matches reset tag, so ok0 tests valid
        cs0 = 1'b1;
        #12;
        chk("rst_mem_cs", 32'(mem_cs), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_data0", 32'(data0), 32'd0);
        chk("rst_data1", 32'(data1), 32'd0);
        chk("rst_ok0", 32'(ok0), 32'd0);
        chk("rst_ok1", 32'(ok1), 32'd0);
        cs0 = 1'b0;
        #20;
        rstn = 1'b1;
        cyc();

        // single read, minimum latency
        lat = 0;
        q_mem.push_back(32'h123);
        q_ok0.push_back(32'hA5);
        cs0 = 1'b1;
        addr0 = 17'h00123;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("lat_ok0_c%0d", k), 32'(ok0), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("single_data0", 32'(data0), 32'hA5);
        chk("single_ok1", 32'(ok1), 32'd0);
        drop_all();

        // ch1 alone so that ch1 is the last served
        q_mem.push_back(32'h21);
        q_ok1.push_back(32'h7B);
        cs1 = 1'b1;
        addr1 = 17'h00021;
        wait_ok(1, 100);
        drop_all();

        // tie: ch0 first
        q_mem.push_back(32'h10);
        q_mem.push_back(32'h20);
        q_ok0.push_back(32'h4A);
        q_ok1.push_back(32'h7A);
        cs0 = 1'b1; addr0 = 17'h00010;
        cs1 = 1'b1; addr1 = 17'h00020;
        wait_ok(0, 100);
        chk("tie1_ok1_pending", 32'(ok1), 32'd0);
        wait_ok(1, 100);
        chk("tie1_ok0_held", 32'(ok0), 32'd1);
        drop_all();

        // ch0 alone, then tie: ch1 first
        q_mem.push_back(32'h11);
        q_ok0.push_back(32'h4B);
        cs0 = 1'b1; addr0 = 17'h00011;
        wait_ok(0, 100);
        drop_all();
        q_mem.push_back(32'h22);
        q_mem.push_back(32'h12);
        q_ok1.push_back(32'h78);
        q_ok0.push_back(32'h48);
        cs0 = 1'b1; addr0 = 17'h00012;
        cs1 = 1'b1; addr1 = 17'h00022;
        wait_ok(1, 100);
        chk("tie2_ok0_pending", 32'(ok0), 32'd0);
        wait_ok(0, 100);
        drop_all();

        // stalled memory
        lat = 50;
        q_mem.push_back(32'h30);
        q_ok0.push_back(32'h6A);
        cs0 = 1'b1; addr0 = 17'h00030;
        wait_mem_cs(20);
        begin
            int bad = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (!mem_cs || mem_addr != 17'h00030 || ok0) bad++;
            end
            chk("stall_hold_errors", 32'(bad), 32'd0);
        end
        wait_ok(0, 20);
        chk("stall_data0", 32'(data0), 32'h6A);
        drop_all();

        // mid-access abandon
        lat = 3;
        q_mem.push_back(32'h40);
        q_mem.push_back(32'h41);
        q_ok0.push_back(32'h1B);
        cs0 = 1'b1; addr0 = 17'h00040;
        wait_mem_cs(20);
        cyc();
        addr0 = 17'h00041;
        wait_ok(0, 100);
        chk("abandon_data0", 32'(data0), 32'h1B);
        drop_all();

        // re-read after cs drop
        lat = 0;
        q_mem.push_back(32'h55);
        q_ok0.push_back(32'h3C);
        cs0 = 1'b1; addr0 = 17'h00055;
        wait_ok(0, 100);
        cyc();
        cs0 = 1'b0;
        cyc();
        q_ok0.push_back(32'h3C);
`ifndef JT7759_ARB_CACHE_EN
        q_mem.push_back(32'h55);
`endif
        cs0 = 1'b1;
        @(negedge clk);
`ifdef JT7759_ARB_CACHE_EN
        chk("reread_hit_ok0", 32'(ok0), 32'd1);
        chk("reread_hit_data0", 32'(data0), 32'h3C);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("reread_no_mem_cs", 32'(mem_cs), 32'd0);
        end
`else
        chk("reread_miss_ok0", 32'(ok0), 32'd0);
        wait_ok(0, 100);
        chk("reread_data0", 32'(data0), 32'h3C);
`endif
        drop_all();

        // async reset mid-WAIT while ch1 holds a hit
        lat = 0;
        q_mem.push_back(32'h70);
        q_ok1.push_back(32'h2A);
        cs1 = 1'b1; addr1 = 17'h00070;
        wait_ok(1, 100);
        lat = 20;
        q_mem.push_back(32'h60);
        cyc();
        cs0 = 1'b1; addr0 = 17'h00060;
        wait_mem_cs(20);
        cyc();
        cyc();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_mem_cs", 32'(mem_cs), 32'd0);
        chk("arst_ok0", 32'(ok0), 32'd0);
        chk("arst_ok1", 32'(ok1), 32'd0);
        auto_mem = 1'b0;
        cs0 = 1'b0;
        cs1 = 1'b0;
        #20;
        rstn = 1'b1;
        cyc();
        stray_cnt = 2;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("stray_mem_cs", 32'(mem_cs), 32'd0);
        end
        cyc();
        auto_mem = 1'b1;
        lat = 0;
        q_mem.push_back(32'h0);
        q_ok0.push_back(32'h5A);
        cs0 = 1'b1; addr0 = 17'h00000;
        #1;
        chk("stray_ok0", 32'(ok0), 32'd0);
        wait_ok(0, 100);
        drop_all();

        chk("q_mem_empty", 32'(q_mem.size()), 32'd0);
        chk("q_ok0_empty", 32'(q_ok0.size()), 32'd0);
        chk("q_ok1_empty", 32'(q_ok1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
